// File: rtl/priority_merge_pkg.sv
// -----------------------------------------------------------------------------
// priority_merge_pkg
// Shared types, constants and helpers for the N-input packet-aware priority
// merge and its 2-entry output buffer.
//   arb_state_t  : arbiter state (IDLE, LOCKED)
//   COUNT_*      : occupancy codes of the 2-entry output buffer
//   prio_encode  : index of the lowest set bit of a 32-bit vector
//                  (callers zero-extend narrower request vectors; 0 if none)
// -----------------------------------------------------------------------------
package priority_merge_pkg;

   typedef enum logic [0:0] {
      IDLE   = 1'b0,
      LOCKED = 1'b1
   } arb_state_t;

   localparam int BUF_DEPTH = 2;
   localparam int COUNT_W   = 2;

   localparam logic [COUNT_W-1:0] COUNT_EMPTY = 2'd0;
   localparam logic [COUNT_W-1:0] COUNT_ONE   = 2'd1;
   localparam logic [COUNT_W-1:0] COUNT_FULL  = 2'd2;

   // Requests wider than this are not supported by prio_encode.
   localparam int PRIO_MAX = 32;

   // Lowest set bit wins; scanning downward lets the lowest index overwrite.
   function automatic int prio_encode(input logic [PRIO_MAX-1:0] vec);
      int idx;
      idx = 0;
      for (int i = PRIO_MAX - 1; i >= 0; i--) begin
         if (vec[i]) begin
            idx = i;
         end else begin
            idx = idx;
         end
      end
      return idx;
   endfunction

endpackage

// File: rtl/avalon_st_skid_buffer.sv
// -----------------------------------------------------------------------------
// avalon_st_skid_buffer
// Two-entry register slice for a valid/ready stream. The head register drives
// the output directly; the skid register catches the beat that is already in
// flight when the consumer stalls. in_ready depends only on the occupancy
// register, never on out_ready, so no combinational ready path crosses it.
// The head payload is cleared whenever the buffer is empty, so the output
// payload reads zero while out_valid is low.
//
// Parameters
//   PAYLOAD     : bits per beat
// Ports
//   clock       : rising-edge clock
//   reset       : asynchronous, active-high reset
//   in_valid    : upstream beat valid
//   in_ready    : buffer can accept a beat (occupancy < 2)
//   in_payload  : upstream beat
//   out_valid   : head beat valid (registered)
//   out_ready   : downstream ready
//   out_payload : head beat (registered)
// -----------------------------------------------------------------------------
module avalon_st_skid_buffer
   import priority_merge_pkg::*;
#(
   parameter int PAYLOAD = 10
) (
   input  logic               clock,
   input  logic               reset,
   input  logic               in_valid,
   output logic               in_ready,
   input  logic [PAYLOAD-1:0] in_payload,
   output logic               out_valid,
   input  logic               out_ready,
   output logic [PAYLOAD-1:0] out_payload
);

   logic [COUNT_W-1:0] count_r;
   logic [COUNT_W-1:0] count_next_s;
   logic [PAYLOAD-1:0] head_r;
   logic [PAYLOAD-1:0] head_next_s;
   logic [PAYLOAD-1:0] skid_r;
   logic [PAYLOAD-1:0] skid_next_s;
   logic               valid_r;
   logic               in_xfer_s;
   logic               out_xfer_s;

   assign in_ready    = (count_r < COUNT_FULL);
   assign in_xfer_s   = in_valid && in_ready;
   assign out_xfer_s  = valid_r && out_ready;
   assign out_valid   = valid_r;
   assign out_payload = head_r;

   // Occupancy and head/skid update for every combination of push and pop.
   always_comb begin
      count_next_s = count_r;
      head_next_s  = head_r;
      skid_next_s  = skid_r;
      case (count_r)
         COUNT_EMPTY: begin
            if (in_xfer_s) begin
               head_next_s  = in_payload;
               count_next_s = COUNT_ONE;
            end else begin
               head_next_s  = '0;
            end
         end
         COUNT_ONE: begin
            if (in_xfer_s && out_xfer_s) begin
               // Head leaves and the new beat takes its place.
               head_next_s  = in_payload;
            end else if (in_xfer_s) begin
               skid_next_s  = in_payload;
               count_next_s = COUNT_FULL;
            end else if (out_xfer_s) begin
               head_next_s  = '0;
               count_next_s = COUNT_EMPTY;
            end else begin
               head_next_s  = head_r;
            end
         end
         COUNT_FULL: begin
            // in_ready is low here, so only a pop can happen.
            if (out_xfer_s) begin
               head_next_s  = skid_r;
               skid_next_s  = '0;
               count_next_s = COUNT_ONE;
            end else begin
               head_next_s  = head_r;
            end
         end
         default: begin
            count_next_s = COUNT_EMPTY;
            head_next_s  = '0;
            skid_next_s  = '0;
         end
      endcase
   end

   // Buffer state registers; reset discards any buffered beats.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         count_r <= COUNT_EMPTY;
         head_r  <= '0;
         skid_r  <= '0;
         valid_r <= 1'b0;
      end else begin
         count_r <= count_next_s;
         head_r  <= head_next_s;
         skid_r  <= skid_next_s;
         valid_r <= (count_next_s != COUNT_EMPTY);
      end
   end

endmodule

// File: rtl/priority_merge_n_avalon_st.sv
// -----------------------------------------------------------------------------
// priority_merge_n_avalon_st
// Packet-aware fixed-priority merge of CHANNELS Avalon-ST inputs into one
// output stream. Channel 0 has the highest priority. A channel whose accepted
// beat opens a multi-beat packet (sop=1, eop=0) holds the grant until its eop
// beat is accepted, so packets never interleave. Beats go through a 2-entry
// output buffer: one cycle latency, full throughput, and in_ready that is a
// function of registered state and in_valid only.
//
// Optional feature (macro PRIORITY_MERGE_N_CHANNEL_EN):
//   adds the out_channel port; the source index travels with each buffered
//   beat and is presented alongside it. Without the macro the port and the
//   storage are absent.
//
// Parameters
//   WIDTH             : data bits per beat
//   CHANNELS          : number of inputs (2..32)
// Ports
//   clock             : rising-edge clock
//   reset             : asynchronous, active-high reset
//   in_ready          : per-channel ready (only the granted channel can be 1)
//   in_valid          : per-channel valid
//   in_data           : per-channel data, unpacked [CHANNELS]
//   in_startofpacket  : per-channel SOP
//   in_endofpacket    : per-channel EOP
//   out_ready         : downstream ready
//   out_valid         : head beat valid
//   out_data          : head beat data (0 when empty)
//   out_startofpacket : head beat SOP (0 when empty)
//   out_endofpacket   : head beat EOP (0 when empty)
//   out_channel       : head beat source channel (macro only, 0 when empty)
// -----------------------------------------------------------------------------
module priority_merge_n_avalon_st
   import priority_merge_pkg::*;
#(
   parameter int WIDTH    = 8,
   parameter int CHANNELS = 4
) (
   input  logic                        clock,
   input  logic                        reset,
   output logic [CHANNELS-1:0]         in_ready,
   input  logic [CHANNELS-1:0]         in_valid,
   input  logic [WIDTH-1:0]            in_data [CHANNELS],
   input  logic [CHANNELS-1:0]         in_startofpacket,
   input  logic [CHANNELS-1:0]         in_endofpacket,
   input  logic                        out_ready,
   output logic                        out_valid,
   output logic [WIDTH-1:0]            out_data,
   output logic                        out_startofpacket,
   output logic                        out_endofpacket
`ifdef PRIORITY_MERGE_N_CHANNEL_EN
   ,
   output logic [$clog2(CHANNELS)-1:0] out_channel
`endif
);

   localparam int CH_W = $clog2(CHANNELS);

`ifdef PRIORITY_MERGE_N_CHANNEL_EN
   localparam int PAYLOAD = WIDTH + 2 + CH_W;
`else
   localparam int PAYLOAD = WIDTH + 2;
`endif

   arb_state_t          state_r;
   arb_state_t          state_next_s;
   logic [CH_W-1:0]     lock_r;
   logic [CH_W-1:0]     lock_next_s;

   logic [PRIO_MAX-1:0] valid_ext_s;
   logic [CH_W-1:0]     grant_s;
   logic                grant_valid_s;

   logic                sel_valid_s;
   logic [WIDTH-1:0]    sel_data_s;
   logic                sel_sop_s;
   logic                sel_eop_s;
   logic                in_xfer_s;

   logic                buf_in_ready_s;
   logic [PAYLOAD-1:0]  buf_in_payload_s;
   logic [PAYLOAD-1:0]  buf_out_payload_s;

   // Grant: locked channel while a packet is open, otherwise lowest-index valid.
   always_comb begin
      valid_ext_s                 = '0;
      valid_ext_s[CHANNELS-1:0]   = in_valid;
      if (state_r == LOCKED) begin
         grant_s       = lock_r;
         grant_valid_s = 1'b1;
      end else begin
         grant_s       = CH_W'(prio_encode(valid_ext_s));
         grant_valid_s = |in_valid;
      end
   end

   // Ready goes to the granted channel only, gated by buffer space.
   always_comb begin
      in_ready = '0;
      for (int i = 0; i < CHANNELS; i++) begin
         if (grant_valid_s && (grant_s == CH_W'(i))) begin
            in_ready[i] = buf_in_ready_s;
         end else begin
            in_ready[i] = 1'b0;
         end
      end
   end

   assign sel_valid_s = grant_valid_s && in_valid[grant_s];
   assign sel_data_s  = in_data[grant_s];
   assign sel_sop_s   = in_startofpacket[grant_s];
   assign sel_eop_s   = in_endofpacket[grant_s];
   assign in_xfer_s   = sel_valid_s && buf_in_ready_s;

   // Arbiter next state: open a lock on sop-without-eop, release on eop.
   always_comb begin
      state_next_s = state_r;
      lock_next_s  = lock_r;
      case (state_r)
         IDLE: begin
            if (in_xfer_s && sel_sop_s && !sel_eop_s) begin
               state_next_s = LOCKED;
               lock_next_s  = grant_s;
            end else begin
               state_next_s = IDLE;
            end
         end
         LOCKED: begin
            // A sop inside an open packet is forwarded but does not re-lock.
            if (in_xfer_s && sel_eop_s) begin
               state_next_s = IDLE;
            end else begin
               state_next_s = LOCKED;
            end
         end
         default: begin
            state_next_s = IDLE;
            lock_next_s  = '0;
         end
      endcase
   end

   // Arbiter state and lock registers.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state_r <= IDLE;
         lock_r  <= '0;
      end else begin
         state_r <= state_next_s;
         lock_r  <= lock_next_s;
      end
   end

`ifdef PRIORITY_MERGE_N_CHANNEL_EN
   assign buf_in_payload_s = {grant_s, sel_data_s, sel_sop_s, sel_eop_s};
   assign {out_channel, out_data, out_startofpacket, out_endofpacket} = buf_out_payload_s;
`else
   assign buf_in_payload_s = {sel_data_s, sel_sop_s, sel_eop_s};
   assign {out_data, out_startofpacket, out_endofpacket} = buf_out_payload_s;
`endif

   avalon_st_skid_buffer #(
      .PAYLOAD (PAYLOAD)
   ) u_out_buffer (
      .clock       (clock),
      .reset       (reset),
      .in_valid    (sel_valid_s),
      .in_ready    (buf_in_ready_s),
      .in_payload  (buf_in_payload_s),
      .out_valid   (out_valid),
      .out_ready   (out_ready),
      .out_payload (buf_out_payload_s)
   );

endmodule

// File: tb/tb_priority_merge_n_avalon_st.sv
`timescale 1ns/1ps
module tb_priority_merge_n_avalon_st;

   localparam int WIDTH    = 8;
   localparam int CHANNELS = 4;
   localparam int MAXB     = 16;

   logic                clock = 1'b0;
   logic                reset = 1'b1;
   logic [CHANNELS-1:0] in_ready;
   logic [CHANNELS-1:0] in_valid;
   logic [WIDTH-1:0]    in_data [CHANNELS];
   logic [CHANNELS-1:0] in_sop;
   logic [CHANNELS-1:0] in_eop;
   logic                out_ready;
   logic                out_valid;
   logic [WIDTH-1:0]    out_data;
   logic                out_sop;
   logic                out_eop;
`ifdef PRIORITY_MERGE_N_CHANNEL_EN
   logic [1:0]          out_channel;
`endif

   typedef struct packed {
      logic [7:0] data;
      logic       sop;
      logic       eop;
      logic [1:0] ch;
   } beat_t;

   // Stimulus tables, per channel
   beat_t stim [CHANNELS][MAXB];
   int    stim_len   [CHANNELS];
   int    stim_ptr   [CHANNELS];
   int    stim_start [CHANNELS];
   int    stall_lo;
   int    stall_hi;
   int    cyc;

   // Scoreboard and output log
   beat_t      exp_q[$];
   logic [7:0] log_data[$];
   int         log_cyc[$];

   // Reference arbiter/buffer model
   logic       m_locked;
   logic [1:0] m_lock;
   int         m_count;
   logic       saw_full;

   int checks   = 0;
   int failures = 0;

   priority_merge_n_avalon_st #(.WIDTH(WIDTH), .CHANNELS(CHANNELS)) dut (
      .clock             (clock),
      .reset             (reset),
      .in_ready          (in_ready),
      .in_valid          (in_valid),
      .in_data           (in_data),
      .in_startofpacket  (in_sop),
      .in_endofpacket    (in_eop),
      .out_ready         (out_ready),
      .out_valid         (out_valid),
      .out_data          (out_data),
      .out_startofpacket (out_sop),
      .out_endofpacket   (out_eop)
`ifdef PRIORITY_MERGE_N_CHANNEL_EN
      ,
      .out_channel       (out_channel)
`endif
   );

   always #5 clock = ~clock;

   task automatic clear_stim();
      for (int c = 0; c < CHANNELS; c++) begin
         stim_len[c]   = 0;
         stim_ptr[c]   = 0;
         stim_start[c] = 0;
      end
      stall_lo = -1;
      stall_hi = -1;
      log_data.delete();
      log_cyc.delete();
      saw_full = 1'b0;
   endtask

   task automatic add_beat(input int c, input logic [7:0] d, input logic s, input logic e);
      stim[c][stim_len[c]] = '{data: d, sop: s, eop: e, ch: 2'(c)};
      stim_len[c]++;
   endtask

   task automatic reset_model();
      m_locked = 1'b0;
      m_lock   = 2'd0;
      m_count  = 0;
      exp_q.delete();
   endtask

   function automatic logic pending();
      logic p;
      p = 1'b0;
      for (int c = 0; c < CHANNELS; c++) begin
         if (stim_ptr[c] < stim_len[c]) p = 1'b1;
      end
      return p;
   endfunction

   task automatic drive();
      beat_t b;
      for (int c = 0; c < CHANNELS; c++) begin
         if (stim_ptr[c] < stim_len[c] && cyc >= stim_start[c]) begin
            b = stim[c][stim_ptr[c]];
            in_valid[c] = 1'b1;
            in_data[c]  = b.data;
            in_sop[c]   = b.sop;
            in_eop[c]   = b.eop;
         end else begin
            in_valid[c] = 1'b0;
            in_data[c]  = 8'h00;
            in_sop[c]   = 1'b0;
            in_eop[c]   = 1'b0;
         end
      end
      out_ready = !(cyc >= stall_lo && cyc < stall_hi);
   endtask

   // One clock cycle: drive, check at negedge against the model, advance.
   task automatic step();
      logic [1:0]          m_grant;
      logic                m_gv;
      logic                m_in;
      logic                m_out;
      logic [CHANNELS-1:0] exp_ready;
      beat_t               b;
      drive();
      @(negedge clock);
      if (m_locked) begin
         m_grant = m_lock;
         m_gv    = 1'b1;
      end else begin
         m_grant = 2'd0;
         m_gv    = |in_valid;
         for (int i = CHANNELS - 1; i >= 0; i--) begin
            if (in_valid[i]) m_grant = 2'(i);
         end
      end
      exp_ready = '0;
      if (m_gv && m_count < 2) exp_ready[m_grant] = 1'b1;
      if (m_gv) begin
         checks++;
         if (in_ready !== exp_ready) begin
            failures++;
            $display("FAIL in_ready cyc=%0d got=%b expected=%b", cyc, in_ready, exp_ready);
         end
      end
      if (in_valid != '0 && in_ready == '0 && out_valid) saw_full = 1'b1;
      m_in  = m_gv && in_valid[m_grant] && (m_count < 2);
      m_out = (m_count != 0) && out_ready;
      checks++;
      if (out_valid !== (m_count != 0)) begin
         failures++;
         $display("FAIL out_valid cyc=%0d got=%b expected=%b", cyc, out_valid, (m_count != 0));
      end
      if (m_count != 0) begin
         checks++;
         if ({out_data, out_sop, out_eop} !== {exp_q[0].data, exp_q[0].sop, exp_q[0].eop}) begin
            failures++;
            $display("FAIL out_beat cyc=%0d got=%h/%b/%b expected=%h/%b/%b", cyc, out_data, out_sop,
                     out_eop, exp_q[0].data, exp_q[0].sop, exp_q[0].eop);
         end
`ifdef PRIORITY_MERGE_N_CHANNEL_EN
         checks++;
         if (out_channel !== exp_q[0].ch) begin
            failures++;
            $display("FAIL out_channel cyc=%0d got=%0d expected=%0d", cyc, out_channel, exp_q[0].ch);
         end
`endif
      end else begin
         checks++;
         if ({out_data, out_sop, out_eop} !== 10'd0) begin
            failures++;
            $display("FAIL out_empty_zero cyc=%0d got=%h/%b/%b expected=0", cyc, out_data, out_sop, out_eop);
         end
      end
      if (m_out) begin
         b = exp_q.pop_front();
         log_data.push_back(b.data);
         log_cyc.push_back(cyc);
      end
      if (m_in) begin
         b = stim[m_grant][stim_ptr[m_grant]];
         exp_q.push_back(b);
         stim_ptr[m_grant]++;
         if (!m_locked && b.sop && !b.eop) begin
            m_locked = 1'b1;
            m_lock   = m_grant;
         end else if (m_locked && b.eop) begin
            m_locked = 1'b0;
         end
      end
      m_count = m_count + int'(m_in) - int'(m_out);
      @(posedge clock);
      #1;
      cyc++;
   endtask

   task automatic run(input int max_cycles);
      cyc = 0;
      while ((pending() || m_count != 0) && cyc < max_cycles) step();
      checks++;
      if (pending() || m_count != 0) begin
         failures++;
         $display("FAIL timeout budget=%0d got=pending expected=drained", max_cycles);
      end
   endtask

   task automatic test_reset();
      in_valid  = 4'b0110;
      out_ready = 1'b1;
      reset     = 1'b1;
      @(posedge clock);
      @(posedge clock);
      #1;
      checks++;
      if ({out_valid, out_data, out_sop, out_eop} !== 11'd0) begin
         failures++;
         $display("FAIL reset_outputs got=%b/%h/%b/%b expected=0", out_valid, out_data, out_sop, out_eop);
      end
`ifdef PRIORITY_MERGE_N_CHANNEL_EN
      checks++;
      if (out_channel !== 2'd0) begin
         failures++;
         $display("FAIL reset_channel got=%0d expected=0", out_channel);
      end
`endif
      checks++;
      if (in_ready !== 4'b0010) begin
         failures++;
         $display("FAIL reset_in_ready got=%b expected=0010", in_ready);
      end
      in_valid = '0;
      reset    = 1'b0;
      reset_model();
      @(posedge clock);
      #1;
   endtask

   task automatic test_single_channel();
      logic [7:0] ev[$] = '{8'h11, 8'h22, 8'h33};
      clear_stim();
      add_beat(2, 8'h11, 1'b1, 1'b0);
      add_beat(2, 8'h22, 1'b0, 1'b0);
      add_beat(2, 8'h33, 1'b0, 1'b1);
      run(30);
      checks++;
      if (log_data.size() != 3) begin
         failures++;
         $display("FAIL single_count got=%0d expected=3", log_data.size());
      end else begin
         for (int i = 0; i < 3; i++) begin
            checks++;
            if (log_data[i] !== ev[i]) begin
               failures++;
               $display("FAIL single_order idx=%0d got=%h expected=%h", i, log_data[i], ev[i]);
            end
         end
         checks++;
         if (log_cyc[0] != 1 || log_cyc[1] != 2 || log_cyc[2] != 3) begin
            failures++;
            $display("FAIL single_timing got=%0d,%0d,%0d expected=1,2,3", log_cyc[0], log_cyc[1], log_cyc[2]);
         end
      end
   endtask

   task automatic test_priority();
      clear_stim();
      add_beat(1, 8'hA1, 1'b1, 1'b1);
      add_beat(3, 8'hC3, 1'b1, 1'b1);
      run(30);
      checks++;
      if (log_data.size() != 2 || log_data[0] !== 8'hA1 || log_data[1] !== 8'hC3) begin
         failures++;
         $display("FAIL priority_order got_n=%0d expected=A1,C3", log_data.size());
      end
   endtask

   task automatic test_packet_lock();
      logic [7:0] ev[$] = '{8'h30, 8'h31, 8'h32, 8'h33, 8'h05};
      clear_stim();
      add_beat(3, 8'h30, 1'b1, 1'b0);
      add_beat(3, 8'h31, 1'b0, 1'b0);
      add_beat(3, 8'h32, 1'b0, 1'b0);
      add_beat(3, 8'h33, 1'b0, 1'b1);
      add_beat(0, 8'h05, 1'b1, 1'b1);
      stim_start[0] = 1;
      run(40);
      checks++;
      if (log_data.size() != 5) begin
         failures++;
         $display("FAIL lock_count got=%0d expected=5", log_data.size());
      end else begin
         for (int i = 0; i < 5; i++) begin
            checks++;
            if (log_data[i] !== ev[i]) begin
               failures++;
               $display("FAIL lock_order idx=%0d got=%h expected=%h", i, log_data[i], ev[i]);
            end
         end
         checks++;
         if (log_cyc[4] != log_cyc[3] + 1) begin
            failures++;
            $display("FAIL lock_followon got=%0d expected=%0d", log_cyc[4], log_cyc[3] + 1);
         end
      end
   endtask

   task automatic test_backpressure();
      logic [7:0] ev[$] = '{8'h60, 8'h61, 8'h62, 8'h63, 8'h64, 8'h65, 8'h0B};
      clear_stim();
      add_beat(1, 8'h60, 1'b1, 1'b0);
      add_beat(1, 8'h61, 1'b0, 1'b0);
      add_beat(1, 8'h62, 1'b0, 1'b0);
      add_beat(1, 8'h63, 1'b1, 1'b0);
      add_beat(1, 8'h64, 1'b0, 1'b0);
      add_beat(1, 8'h65, 1'b0, 1'b1);
      add_beat(0, 8'h0B, 1'b1, 1'b1);
      stim_start[0] = 2;
      stall_lo      = 2;
      stall_hi      = 5;
      run(60);
      checks++;
      if (saw_full !== 1'b1) begin
         failures++;
         $display("FAIL bp_full got=%b expected=1", saw_full);
      end
      checks++;
      if (log_data.size() != 7) begin
         failures++;
         $display("FAIL bp_count got=%0d expected=7", log_data.size());
      end else begin
         for (int i = 0; i < 7; i++) begin
            checks++;
            if (log_data[i] !== ev[i]) begin
               failures++;
               $display("FAIL bp_order idx=%0d got=%h expected=%h", i, log_data[i], ev[i]);
            end
         end
      end
   endtask

   task automatic test_reset_mid_packet();
      logic [7:0] ev[$] = '{8'h5A, 8'h42, 8'h43};
      clear_stim();
      add_beat(3, 8'h40, 1'b1, 1'b0);
      add_beat(3, 8'h41, 1'b0, 1'b0);
      add_beat(3, 8'h42, 1'b0, 1'b0);
      add_beat(3, 8'h43, 1'b0, 1'b1);
      cyc = 0;
      step();
      step();
      drive();
      reset = 1'b1;
      #1;
      checks++;
      if ({out_valid, out_data, out_sop, out_eop} !== 11'd0) begin
         failures++;
         $display("FAIL midreset_out got=%b/%h expected=0/00", out_valid, out_data);
      end
      checks++;
      if (in_ready !== 4'b1000) begin
         failures++;
         $display("FAIL midreset_in_ready got=%b expected=1000", in_ready);
      end
      @(posedge clock);
      #1;
      reset = 1'b0;
      reset_model();
      log_data.delete();
      log_cyc.delete();
      add_beat(0, 8'h5A, 1'b1, 1'b1);
      run(30);
      checks++;
      if (log_data.size() != 3) begin
         failures++;
         $display("FAIL midreset_count got=%0d expected=3", log_data.size());
      end else begin
         for (int i = 0; i < 3; i++) begin
            checks++;
            if (log_data[i] !== ev[i]) begin
               failures++;
               $display("FAIL midreset_order idx=%0d got=%h expected=%h", i, log_data[i], ev[i]);
            end
         end
      end
   endtask

   initial begin
      in_valid  = '0;
      in_sop    = '0;
      in_eop    = '0;
      out_ready = 1'b1;
      for (int c = 0; c < CHANNELS; c++) in_data[c] = 8'h00;
      cyc = 0;
      clear_stim();
      reset_model();
      test_reset();
      test_single_channel();
      test_priority();
      test_packet_lock();
      test_backpressure();
      test_reset_mid_packet();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
